// File: rtl/quadrilatero_sa_dispatcher.sv
// quadrilatero_sa_dispatcher: RAW/saturation hazard gate with registered push into the SA issue queue
module quadrilatero_sa_dispatcher #(
  parameter int N_REGS = 8,
  parameter int MAX_INFLIGHT = 3,
  parameter int INSTR_WIDTH = 32,
  localparam int RW = $clog2(N_REGS),
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [RW-1:0]          rd_i,
  input  logic [RW-1:0]          rs1_i,
  input  logic [RW-1:0]          rs2_i,
  input  logic                   issue_queue_full_i,
  output logic                   dispatch_o,
  output logic [INSTR_WIDTH-1:0] dispatched_instr_o,
  input  logic                   finish_i,
  input  logic [RW-1:0]          finish_rd_i,
  input  logic                   drain_i,
  output logic                   idle_o,
  output logic                   err_o
);
  logic [CW-1:0] cnt [N_REGS];
  logic [N_REGS-1:0] inc, dec;
  logic hazard, accept, all_zero;
  always_comb begin
    hazard = cnt[rs1_i] != '0 || cnt[rs2_i] != '0 || cnt[rd_i] == CW'(MAX_INFLIGHT);
    instr_ready_o = !drain_i && !issue_queue_full_i && !hazard;
    accept = instr_valid_i && instr_ready_o;
    all_zero = 1'b1;
    for (int i = 0; i < N_REGS; i++) begin
      inc[i] = accept && rd_i == RW'(i);
      dec[i] = finish_i && finish_rd_i == RW'(i) && cnt[i] != '0;
      all_zero = all_zero && cnt[i] == '0;
    end
    idle_o = all_zero && !dispatch_o;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_REGS; i++) cnt[i] <= '0;
      dispatch_o <= 1'b0;
      dispatched_instr_o <= '0;
      err_o <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGS; i++) cnt[i] <= cnt[i] + CW'(inc[i]) - CW'(dec[i]);
      dispatch_o <= accept;
      if (accept) dispatched_instr_o <= instr_i;
      if (finish_i && cnt[finish_rd_i] == '0) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_quadrilatero_sa_dispatcher.sv
// tb_quadrilatero_sa_dispatcher: directed and random checks against a per-register pending-count model
module tb_quadrilatero_sa_dispatcher;
  localparam int N = 8, M = 3, W = 32;
  logic clk_i = 0, rst_ni = 1;
  logic instr_valid_i = 0, issue_queue_full_i = 0, finish_i = 0, drain_i = 0;
  logic [W-1:0] instr_i = '0;
  logic [2:0] rd_i = '0, rs1_i = '0, rs2_i = '0, finish_rd_i = '0;
  logic instr_ready_o, dispatch_o, idle_o, err_o;
  logic [W-1:0] dispatched_instr_o;
  int mc [N];
  bit merr, mdisp;
  logic [W-1:0] mpay;
  int vectors = 0, miscompares = 0;

  quadrilatero_sa_dispatcher dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .issue_queue_full_i(issue_queue_full_i), .dispatch_o(dispatch_o),
    .dispatched_instr_o(dispatched_instr_o), .finish_i(finish_i), .finish_rd_i(finish_rd_i),
    .drain_i(drain_i), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !drain_i && !issue_queue_full_i && mc[rs1_i] == 0 && mc[rs2_i] == 0 && mc[rd_i] < M;
  endfunction

  function automatic bit m_idle();
    foreach (mc[i]) if (mc[i] != 0) return 0;
    return !mdisp;
  endfunction

  task automatic drv(bit v, int rd, int rs1, int rs2, bit full = 0, bit fin = 0, int frd = 0, bit drn = 0);
    instr_valid_i = v; rd_i = 3'(rd); rs1_i = 3'(rs1); rs2_i = 3'(rs2);
    issue_queue_full_i = full; finish_i = fin; finish_rd_i = 3'(frd); drain_i = drn;
    instr_i = $urandom;
  endtask

  // called just after a falling edge; checks this cycle, then advances the model over the rising edge
  task automatic cycle(string tag, int er = -1);
    bit acc, fok;
    #1;
    if (er >= 0) chk({tag, "_ready_k"}, W'(instr_ready_o), W'(er));
    chk({tag, "_ready"}, W'(instr_ready_o), W'(m_ready()));
    chk({tag, "_dispatch"}, W'(dispatch_o), W'(mdisp));
    chk({tag, "_payload"}, dispatched_instr_o, mpay);
    chk({tag, "_idle"}, W'(idle_o), W'(m_idle()));
    chk({tag, "_err"}, W'(err_o), W'(merr));
    acc = instr_valid_i && m_ready();
    fok = mc[finish_rd_i] > 0;
    @(posedge clk_i);
    if (acc) mc[rd_i]++;
    if (finish_i) begin
      if (fok) mc[finish_rd_i]--;
      else merr = 1;
    end
    mdisp = acc;
    if (acc) mpay = instr_i;
    @(negedge clk_i);
  endtask

  task automatic do_reset(string tag);
    rst_ni = 0;
    #1;
    foreach (mc[i]) mc[i] = 0;
    merr = 0; mdisp = 0; mpay = '0;
    chk({tag, "_rst_dispatch"}, W'(dispatch_o), 0);
    chk({tag, "_rst_payload"}, dispatched_instr_o, 0);
    chk({tag, "_rst_idle"}, W'(idle_o), 1);
    chk({tag, "_rst_err"}, W'(err_o), 0);
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  initial begin
    #2;
    drv(0, 0, 0, 0);
    do_reset("t0");
    drv(1, 2, 0, 1); cycle("t1_acc", 1);
    drv(0, 0, 0, 0); cycle("t1_disp");
    chk("t1_dispatch_k", W'(dispatch_o), 0);
    chk("t1_idle_k", W'(idle_o), 0);
    drv(1, 3, 0, 1); cycle("t2_acc", 1);
    drv(1, 7, 3, 0); cycle("t2_raw", 0);
    drv(1, 7, 3, 0, 0, 1, 3); cycle("t2_fin_same", 0);
    drv(1, 7, 3, 0); cycle("t2_after", 1);
    for (int k = 0; k < 3; k++) begin
      drv(1, 4, 0, 1); cycle("t3_chain", 1);
    end
    drv(1, 4, 0, 1); cycle("t3_sat", 0);
    drv(1, 4, 0, 1, 0, 1, 4); cycle("t3_sat_fin", 0);
    drv(1, 4, 0, 1); cycle("t3_unsat", 1);
    drv(1, 5, 0, 1, 1); cycle("t4_full", 0);
    drv(1, 5, 0, 1); cycle("t4_free", 1);
    drv(0, 0, 0, 0); cycle("t4_disp");
    drv(1, 5, 0, 1, 0, 1, 5); cycle("t5_accfin", 1);
    drv(1, 5, 0, 1); cycle("t5_c2", 1);
    drv(1, 5, 0, 1); cycle("t5_c3", 1);
    drv(1, 5, 0, 1); cycle("t5_c4", 0);
    drv(0, 0, 0, 0, 0, 1, 6); cycle("t5_errfin");
    drv(0, 0, 0, 0); cycle("t5_err");
    chk("t5_err_k", W'(err_o), 1);
    drv(0, 0, 0, 0); cycle("t5_sticky");
    do_reset("t6");
    drv(1, 1, 0, 0); cycle("t6_a1", 1);
    drv(1, 2, 0, 0); cycle("t6_a2", 1);
    drv(1, 3, 0, 0, 0, 0, 0, 1); cycle("t6_drain", 0);
    drv(1, 3, 0, 0, 0, 1, 1, 1); cycle("t6_fin1", 0);
    drv(0, 0, 0, 0, 0, 1, 2, 1); cycle("t6_fin2", 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1); cycle("t6_idle");
    chk("t6_idle_k", W'(idle_o), 1);
    drv(1, 6, 0, 0); cycle("t6_pre", 1);
    drv(1, 7, 0, 0);
    #3;
    do_reset("t6_mid");
    for (int k = 0; k < 400; k++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7),
          $urandom_range(0, 15) == 0);
      cycle("rnd");
      if (k == 200) begin
        #3;
        do_reset("rnd_mid");
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
